// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command/register-file slave.
// Contents:
//   - opcode constants for the first byte of a frame
//   - idle response byte
//   - bit positions of the sticky status flags
//   - frame decoder state encoding
package spi_cmd_pkg;

    localparam logic [7:0] OP_START   = 8'h06;
    localparam logic [7:0] OP_STOP    = 8'h04;
    localparam logic [7:0] OP_WR_BASE = 8'h90;
    localparam logic [7:0] OP_RD_BASE = 8'hA0;
    localparam logic [7:0] OP_STATUS  = 8'hAF;

    localparam logic [7:0] RESP_IDLE  = 8'hFF;

    localparam int ST_BAD_OP    = 0;
    localparam int ST_CRC_ERR   = 1;
    localparam int ST_FRAME_ERR = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_PAYLOAD,
        S_W_CHECK,
        S_R_PAYLOAD,
        S_R_CSUM,
        S_R_STATUS,
        S_DISCARD
    } state_t;

endpackage

// File: rtl/spi_slave_driver.sv
// Byte-level SPI slave, MSB first, oversampled in the clk domain.
// Ports:
//   clk, rst_n      system clock, async active-low reset
//   mode            {CPOL, CPHA}
//   sclk, cs_n,mosi SPI pins (asynchronous to clk)
//   miso            SPI data out, idles high while cs_n is high
//   response_data   byte shifted out during the next transfer
//   rec_data        last received byte
//   rec_valid       one-cycle strobe when rec_data is new
module spi_slave_driver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] response_data,
    output logic [7:0] rec_data,
    output logic       rec_valid
);

    logic [2:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       sample_on_rise;
    logic       sample_edge;
    logic       shift_edge;
    logic       cs_active;

    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
    assign sample_on_rise = ~(mode[1] ^ mode[0]);
    assign sclk_rise      = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall      = ~sclk_sync[1] & sclk_sync[2];
    assign sample_edge    = sample_on_rise ? sclk_rise : sclk_fall;
    assign shift_edge     = sample_on_rise ? sclk_fall : sclk_rise;
    assign cs_active      = ~cs_sync[1];

    assign miso = cs_n ? 1'b1 : tx_shift[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= 3'b000;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            cs_sync   <= {cs_sync[0], cs_n};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    // Between bytes (bit_cnt == 0) the transmit register keeps reloading the
    // latest response, so a response written just after rec_valid is still
    // picked up. The shift edge that coincides with a byte boundary is ignored
    // so the MSB is presented for the first bit of every byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 3'd0;
            rx_shift  <= 8'h00;
            tx_shift  <= 8'hFF;
            rec_data  <= 8'h00;
            rec_valid <= 1'b0;
        end else begin
            rec_valid <= 1'b0;
            if (!cs_active) begin
                bit_cnt  <= 3'd0;
                rx_shift <= 8'h00;
            end else if (sample_edge) begin
                rx_shift <= {rx_shift[6:0], mosi_sync[1]};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rec_data  <= {rx_shift[6:0], mosi_sync[1]};
                    rec_valid <= 1'b1;
                end
            end
            if (bit_cnt == 3'd0) begin
                tx_shift <= response_data;
            end else if (shift_edge && cs_active) begin
                tx_shift <= {tx_shift[6:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/spi_slave_cmd_regfile.sv
// SPI command decoder driving a bank of parameter registers.
// Ports:
//   clk, rst_n       system clock, async active-low reset
//   sclk,cs_n,mosi   SPI pins; miso SPI data out
//   machine_start/stop  one-cycle pulses from the START/STOP opcodes
//   reg_data         NUM_REGS registers, register i at [i*DATA_W +: DATA_W]
//   reg_update       one-cycle pulse on bit i when register i commits
//   feedback_data    NUM_FB readable channels, channel j at [j*DATA_W +: DATA_W]
//   err_cnt          saturating count of frame errors
// Writes carry an XOR checksum and commit the whole register at once.
module spi_slave_cmd_regfile
    import spi_cmd_pkg::*;
#(
    parameter int         NUM_REGS       = 4,
    parameter int         NUM_FB         = 2,
    parameter int         DATA_BYTES     = 2,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [1:0] SPI_MODE       = 2'b00
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         cs_n,
    input  logic                         mosi,
    output logic                         miso,
    output logic                         machine_start,
    output logic                         machine_stop,
    output logic [NUM_REGS*8*DATA_BYTES-1:0] reg_data,
    output logic [NUM_REGS-1:0]          reg_update,
    input  logic [NUM_FB*8*DATA_BYTES-1:0] feedback_data,
    output logic [7:0]                   err_cnt
);

    localparam int DATA_W = 8 * DATA_BYTES;
    localparam int IDX_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int IDX1_W = IDX_W + 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]       NUM_REGS_L = 5'(NUM_REGS);
    localparam logic [4:0]       NUM_FB_L   = 5'(NUM_FB);

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        response;
    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  byte_idx;
    logic [IDX1_W-1:0] byte_next;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] snapshot;
    logic [DATA_W-1:0] fb_word;
    logic [7:0]        snap_next;
    logic [7:0]        snap_xor;
    logic [7:0]        csum;
    logic [3:0]        reg_sel;
    logic [2:0]        status;
    logic [2:0]        status_set;
    logic [TO_W-1:0]   to_cnt;
    logic [1:0]        cs_sync;
    logic              cs_prev;
    logic              cs_rise;
    logic              timeout_hit;
    logic              abort;
    logic              frame_fault;
    logic              bad_op_evt;
    logic              crc_evt;
    logic              commit;
    logic              clr_status;
    logic              op_write;
    logic              op_read;
    logic              last_byte;

    spi_slave_driver u_driver (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode          (SPI_MODE),
        .sclk          (sclk),
        .cs_n          (cs_n),
        .mosi          (mosi),
        .miso          (miso),
        .response_data (response),
        .rec_data      (rx_data),
        .rec_valid     (rx_valid)
    );

    assign op_write  = (rx_data[7:4] == OP_WR_BASE[7:4]) && ({1'b0, rx_data[3:0]} < NUM_REGS_L);
    assign op_read   = (rx_data[7:4] == OP_RD_BASE[7:4]) && ({1'b0, rx_data[3:0]} < NUM_FB_L);
    assign last_byte = (byte_idx == LAST_IDX);
    assign byte_next = {1'b0, byte_idx} + IDX1_W'(1);
    assign cs_rise   = cs_sync[1] & ~cs_prev;
    // DISCARD is left only by cs_n going high, so it never times out.
    assign timeout_hit = (state != S_IDLE) && (state != S_DISCARD) && (to_cnt == TO_LIMIT);

    // Byte lanes of the captured feedback word and the channel chosen by the opcode.
    always_comb begin
        snap_next = 8'h00;
        snap_xor  = 8'h00;
        fb_word   = '0;
        for (int b = 0; b < DATA_BYTES; b++) begin
            snap_xor = snap_xor ^ snapshot[8*b +: 8];
            if (byte_next == IDX1_W'(b)) begin
                snap_next = snapshot[8*b +: 8];
            end
        end
        for (int j = 0; j < NUM_FB; j++) begin
            if (rx_data[3:0] == 4'(j)) begin
                fb_word = feedback_data[j*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle events. An aborted frame (cs_n rising or
    // timeout) takes priority over a byte arriving in the same cycle.
    always_comb begin
        state_next  = state;
        abort       = 1'b0;
        frame_fault = 1'b0;
        bad_op_evt  = 1'b0;
        crc_evt     = 1'b0;
        commit      = 1'b0;
        clr_status  = 1'b0;
        if ((state != S_IDLE) && (state != S_DISCARD) && (cs_rise || timeout_hit)) begin
            abort       = 1'b1;
            state_next  = S_IDLE;
            frame_fault = (state == S_W_PAYLOAD) || (state == S_W_CHECK);
        end else if ((state == S_DISCARD) && cs_rise) begin
            state_next = S_IDLE;
        end else if (rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (rx_data == OP_STATUS) begin
                        state_next = S_R_STATUS;
                    end else if (op_write) begin
                        state_next = S_W_PAYLOAD;
                    end else if (op_read) begin
                        state_next = S_R_PAYLOAD;
                    end else if ((rx_data != OP_START) && (rx_data != OP_STOP)) begin
                        bad_op_evt = 1'b1;
                        state_next = S_DISCARD;
                    end
                end
                S_W_PAYLOAD: if (last_byte) state_next = S_W_CHECK;
                S_W_CHECK: begin
                    commit     = (rx_data == csum);
                    crc_evt    = (rx_data != csum);
                    state_next = S_IDLE;
                end
                S_R_PAYLOAD: if (last_byte) state_next = S_R_CSUM;
                S_R_CSUM:    state_next = S_IDLE;
                S_R_STATUS: begin
                    clr_status = 1'b1;
                    state_next = S_IDLE;
                end
                default: state_next = state;
            endcase
        end
        status_set               = 3'b000;
        status_set[ST_BAD_OP]    = bad_op_evt;
        status_set[ST_CRC_ERR]   = crc_evt;
        status_set[ST_FRAME_ERR] = frame_fault;
    end

    // Datapath: shadow buffer, checksum, read snapshot, response byte,
    // registers, pulses, sticky status, error counter and inter-byte timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync       <= 2'b11;
            cs_prev       <= 1'b1;
            to_cnt        <= '0;
            byte_idx      <= '0;
            shadow        <= '0;
            snapshot      <= '0;
            csum          <= 8'h00;
            reg_sel       <= 4'h0;
            response      <= RESP_IDLE;
            status        <= 3'b000;
            err_cnt       <= 8'h00;
            reg_data      <= '0;
            reg_update    <= '0;
            machine_start <= 1'b0;
            machine_stop  <= 1'b0;
        end else begin
            cs_sync       <= {cs_sync[0], cs_n};
            cs_prev       <= cs_sync[1];
            reg_update    <= '0;
            machine_start <= 1'b0;
            machine_stop  <= 1'b0;

            if ((state == S_IDLE) || rx_valid) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_LIMIT) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if ((bad_op_evt || crc_evt || frame_fault) && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
            status <= (clr_status ? 3'b000 : status) | status_set;

            if (abort) begin
                response <= RESP_IDLE;
            end else if (rx_valid) begin
                response <= RESP_IDLE;
                case (state)
                    S_IDLE: begin
                        machine_start <= (rx_data == OP_START);
                        machine_stop  <= (rx_data == OP_STOP);
                        byte_idx      <= '0;
                        reg_sel       <= rx_data[3:0];
                        csum          <= rx_data;
                        if (rx_data == OP_STATUS) begin
                            response <= {5'b00000, status};
                        end else if (op_read) begin
                            snapshot <= fb_word;
                            response <= fb_word[7:0];
                        end
                    end
                    S_W_PAYLOAD: begin
                        for (int b = 0; b < DATA_BYTES; b++) begin
                            if (byte_idx == IDX_W'(b)) begin
                                shadow[8*b +: 8] <= rx_data;
                            end
                        end
                        csum     <= csum ^ rx_data;
                        byte_idx <= byte_idx + IDX_W'(1);
                    end
                    S_W_CHECK: begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (commit && (reg_sel == 4'(i))) begin
                                reg_data[i*DATA_W +: DATA_W] <= shadow;
                                reg_update[i]                <= 1'b1;
                            end
                        end
                    end
                    S_R_PAYLOAD: begin
                        response <= last_byte ? snap_xor : snap_next;
                        byte_idx <= byte_idx + IDX_W'(1);
                    end
                    default: response <= RESP_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_cmd_regfile.sv
// Self-checking bench for spi_slave_cmd_regfile: SPI mode 0 bit-banged
// master, directed frames followed by randomised frames, compared with a
// behavioural model of registers, sticky status and error counter.
module tb_spi_slave_cmd_regfile;

    localparam int NUM_REGS   = 4;
    localparam int NUM_FB     = 2;
    localparam int DATA_BYTES = 2;
    localparam int DATA_W     = 16;
    localparam int TIMEOUT    = 100;
    localparam int HALF       = 4;
    localparam int GAP        = 8;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       sclk = 1'b0;
    logic                       cs_n = 1'b1;
    logic                       mosi = 1'b0;
    logic                       miso;
    logic                       machine_start;
    logic                       machine_stop;
    logic [NUM_REGS*DATA_W-1:0] reg_data;
    logic [NUM_REGS-1:0]        reg_update;
    logic [NUM_FB*DATA_W-1:0]   feedback_data = '0;
    logic [7:0]                 err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_regs [NUM_REGS];
    logic        m_frame, m_crc, m_bad;
    int          m_err;

    int upd_cycles [NUM_REGS];
    int upd_base   [NUM_REGS];
    int start_cycles = 0, stop_cycles = 0, start_base = 0, stop_base = 0;
    logic [7:0] rx_bytes [4];

    spi_slave_cmd_regfile #(
        .NUM_REGS       (NUM_REGS),
        .NUM_FB         (NUM_FB),
        .DATA_BYTES     (DATA_BYTES),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SPI_MODE       (2'b00)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sclk          (sclk),
        .cs_n          (cs_n),
        .mosi          (mosi),
        .miso          (miso),
        .machine_start (machine_start),
        .machine_stop  (machine_stop),
        .reg_data      (reg_data),
        .reg_update    (reg_update),
        .feedback_data (feedback_data),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    // Counts high cycles of each pulse output so pulse width can be checked.
    initial begin
        for (int i = 0; i < NUM_REGS; i++) upd_cycles[i] = 0;
    end
    always @(negedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_update[i]) upd_cycles[i] = upd_cycles[i] + 1;
        end
        if (machine_start) start_cycles = start_cycles + 1;
        if (machine_stop)  stop_cycles  = stop_cycles + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic takeSnapshot();
        for (int i = 0; i < NUM_REGS; i++) upd_base[i] = upd_cycles[i];
        start_base = start_cycles;
        stop_base  = stop_cycles;
    endtask

    task automatic modelError();
        m_err = (m_err < 255) ? m_err + 1 : 255;
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 16'h0000;
        m_frame = 1'b0;
        m_crc   = 1'b0;
        m_bad   = 1'b0;
        m_err   = 0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 7; b >= 0; b--) begin
            mosi = tx[b];
            wait_clk(HALF);
            sclk  = 1'b1;
            rx[b] = miso;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(GAP);
    endtask

    // Sends n bytes in one frame; feedback changes after the first byte.
    task automatic applyStimulus(input int n, input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [7:0] b3, input bit raise_cs);
        logic [7:0] tx [4];
        logic [7:0] r;
        tx[0] = b0; tx[1] = b1; tx[2] = b2; tx[3] = b3;
        cs_n = 1'b0;
        wait_clk(6);
        for (int k = 0; k < n; k++) begin
            spi_byte(tx[k], r);
            rx_bytes[k] = r;
            if (k == 0) feedback_data = {$urandom, $urandom};
        end
        if (raise_cs) begin
            cs_n = 1'b1;
            wait_clk(8);
        end
    endtask

    task automatic checkFrame(input string tag, input int upd_reg, input int exp_start, input int exp_stop);
        for (int i = 0; i < NUM_REGS; i++) begin
            checkOutput({tag, "_reg"}, 64'(reg_data[i*DATA_W +: DATA_W]), 64'(m_regs[i]));
            checkOutput({tag, "_upd"}, 64'(upd_cycles[i] - upd_base[i]), (i == upd_reg) ? 64'd1 : 64'd0);
        end
        checkOutput({tag, "_errcnt"}, 64'(err_cnt), 64'(m_err));
        checkOutput({tag, "_start"}, 64'(start_cycles - start_base), 64'(exp_start));
        checkOutput({tag, "_stop"}, 64'(stop_cycles - stop_base), 64'(exp_stop));
        takeSnapshot();
    endtask

    task automatic doWriteRaw(input int i, input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] cs);
        logic [7:0] op;
        bit good;
        op   = 8'h90 | 8'(i);
        good = (cs == (op ^ lo ^ hi));
        applyStimulus(4, op, lo, hi, cs, 1'b1);
        if (good) begin
            m_regs[i] = {hi, lo};
        end else begin
            m_crc = 1'b1;
            modelError();
        end
        checkFrame("write", good ? i : -1, 0, 0);
    endtask

    task automatic doWrite(input int i, input logic [15:0] d, input bit corrupt);
        logic [7:0] cs;
        cs = (8'h90 | 8'(i)) ^ d[7:0] ^ d[15:8];
        if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
        doWriteRaw(i, d[7:0], d[15:8], cs);
    endtask

    task automatic doRead(input int j);
        logic [15:0] fb;
        fb = 16'($urandom);
        feedback_data[j*DATA_W +: DATA_W] = fb;
        applyStimulus(4, 8'hA0 | 8'(j), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        checkOutput("read_b0", 64'(rx_bytes[0]), 64'hFF);
        checkOutput("read_lo", 64'(rx_bytes[1]), 64'(fb % 256));
        checkOutput("read_hi", 64'(rx_bytes[2]), 64'(fb / 256));
        checkOutput("read_xor", 64'(rx_bytes[3]), 64'((fb % 256) ^ (fb / 256)));
        checkFrame("read", -1, 0, 0);
    endtask

    task automatic doStatus();
        int exp;
        exp = 4 * int'(m_frame) + 2 * int'(m_crc) + int'(m_bad);
        applyStimulus(2, 8'hAF, 8'($urandom), 8'h00, 8'h00, 1'b1);
        checkOutput("status", 64'(rx_bytes[1]), 64'(exp));
        m_frame = 1'b0;
        m_crc   = 1'b0;
        m_bad   = 1'b0;
        checkFrame("status", -1, 0, 0);
    endtask

    task automatic doStartStop(input logic [7:0] op);
        applyStimulus(1, op, 8'h00, 8'h00, 8'h00, 1'b1);
        checkFrame("startstop", -1, (op == 8'h06) ? 1 : 0, (op == 8'h04) ? 1 : 0);
    endtask

    task automatic doBadOp(input logic [7:0] op);
        applyStimulus(4, op, 8'h06, 8'h04, 8'h90, 1'b1);
        m_bad = 1'b1;
        modelError();
        checkFrame("badop", -1, 0, 0);
    endtask

    task automatic doCsAbort(input int i);
        applyStimulus(3, 8'h90 | 8'(i), 8'($urandom), 8'($urandom), 8'h00, 1'b1);
        m_frame = 1'b1;
        modelError();
        checkFrame("csabort", -1, 0, 0);
    endtask

    function automatic logic [7:0] randBadOp();
        if ($urandom_range(0, 1) == 0) return 8'(8'h94 + 8'($urandom_range(0, 11)));
        return 8'(8'hA2 + 8'($urandom_range(0, 12)));
    endfunction

    initial begin
        logic [7:0] r;
        modelReset();
        wait_clk(5);
        checkOutput("rst_regdata", 64'(reg_data), 64'h0);
        checkOutput("rst_update", 64'(reg_update), 64'h0);
        checkOutput("rst_errcnt", 64'(err_cnt), 64'h0);
        checkOutput("rst_pulses", {62'h0, machine_start, machine_stop}, 64'h0);
        checkOutput("rst_miso", 64'(miso), 64'h1);
        rst_n = 1'b1;
        wait_clk(5);
        takeSnapshot();

        $display("[TB] directed write, bad checksum, status");
        doWriteRaw(1, 8'h34, 8'h12, 8'hB7);
        checkOutput("tp1_reg1", 64'(reg_data[31:16]), 64'h1234);
        doWriteRaw(1, 8'h78, 8'h56, 8'h00);
        doStatus();
        doStatus();

        $display("[TB] directed read");
        feedback_data[31:16] = 16'hBEEF;
        applyStimulus(4, 8'hA1, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        checkOutput("tp3_b0", 64'(rx_bytes[0]), 64'hFF);
        checkOutput("tp3_b1", 64'(rx_bytes[1]), 64'hEF);
        checkOutput("tp3_b2", 64'(rx_bytes[2]), 64'hBE);
        checkOutput("tp3_b3", 64'(rx_bytes[3]), 64'h51);

        $display("[TB] write timeout then START in same cs_n window");
        applyStimulus(2, 8'h90, 8'hAA, 8'h00, 8'h00, 1'b0);
        wait_clk(TIMEOUT + 40);
        spi_byte(8'h06, r);
        cs_n = 1'b1;
        wait_clk(8);
        m_frame = 1'b1;
        modelError();
        checkFrame("timeout_wr", -1, 1, 0);

        $display("[TB] read timeout is silent");
        applyStimulus(2, 8'hA1, 8'h00, 8'h00, 8'h00, 1'b0);
        wait_clk(TIMEOUT + 40);
        spi_byte(8'h04, r);
        checkOutput("timeout_rd_resp", 64'(r), 64'hFF);
        cs_n = 1'b1;
        wait_clk(8);
        checkFrame("timeout_rd", -1, 0, 1);
        doStatus();

        $display("[TB] start/stop, bad opcode, opcode bytes as data");
        doStartStop(8'h06);
        doStartStop(8'h04);
        doBadOp(8'h95);
        doWrite(2, 16'h0406, 1'b0);
        doCsAbort(3);
        doStatus();

        $display("[TB] reset mid-frame");
        applyStimulus(2, 8'h93, 8'h55, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b0;
        wait_clk(3);
        checkOutput("midrst_regdata", 64'(reg_data), 64'h0);
        checkOutput("midrst_update", 64'(reg_update), 64'h0);
        checkOutput("midrst_errcnt", 64'(err_cnt), 64'h0);
        cs_n = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        modelReset();
        takeSnapshot();
        doWrite(3, 16'hC0DE, 1'b0);
        doStatus();

        $display("[TB] randomised frames");
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0: doWrite($urandom_range(0, NUM_REGS - 1), 16'($urandom), 1'b0);
                1: doWrite($urandom_range(0, NUM_REGS - 1), 16'($urandom), 1'b1);
                2: doRead($urandom_range(0, NUM_FB - 1));
                3: doStatus();
                4: doStartStop(($urandom_range(0, 1) == 0) ? 8'h06 : 8'h04);
                5: doBadOp(randBadOp());
                default: doCsAbort($urandom_range(0, NUM_REGS - 1));
            endcase
        end

        $display("[TB] error counter saturation");
        for (int n = 0; n < 260; n++) begin
            applyStimulus(1, randBadOp(), 8'h00, 8'h00, 8'h00, 1'b1);
            m_bad = 1'b1;
            modelError();
        end
        checkFrame("saturate", -1, 0, 0);
        checkOutput("saturate_ff", 64'(err_cnt), 64'hFF);
        doStatus();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
